// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared arbiter state encoding and mux select constants
package mux_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker
//   req[1:0] in  : request bits, bit0 = in0, bit1 = in1
//   ptr      in  : tie winner, 0 = in0, 1 = in1
//   win[1:0] out : one-hot winner, 0 when nobody requests
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  assign win = {req[1] & (~req[0] | ptr), req[0] & (~req[1] | ~ptr)};
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin burst arbiter driving a shared 2:1 mux into a one-beat output buffer
//   clk, rst_n                                 : clock, async active-low reset
//   in0_valid/in0_data/in0_last/in0_ready      : requester 0 stream
//   in1_valid/in1_data/in1_last/in1_ready      : requester 1 stream
//   out_valid/out_data/out_last/out_ready      : buffered consumer stream
//   sel                                        : mux select, 0 = in0, 1 = in1
//   grant                                      : one-hot owner, 0 when idle
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic [1:0]       grant
);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t state;
  logic ptr;
  logic [CW-1:0] count;
  logic [1:0] win;
  logic buf_free, own_valid, own_last, acc, rel;
  logic [WIDTH-1:0] mux_data;
  rr_pick2 u_pick (.req({in1_valid, in0_valid}), .ptr(ptr), .win(win));
  assign buf_free  = !out_valid || out_ready;
  assign in0_ready = grant[0] && buf_free;
  assign in1_ready = grant[1] && buf_free;
  // sel always names the owner while locked, so the owner's signals come through the same mux
  assign mux_data  = sel == SEL_IN1 ? in1_data : in0_data;
  assign own_valid = sel == SEL_IN1 ? in1_valid : in0_valid;
  assign own_last  = sel == SEL_IN1 ? in1_last : in0_last;
  assign acc       = |grant && own_valid && buf_free;
  // count holds beats already taken, so this beat reaching MAX_BURST means count == MAX_BURST-1
  assign rel       = acc && (own_last || count == CW'(MAX_BURST - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sel       <= SEL_IN0;
      grant     <= 2'b00;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= own_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE && win[0]) begin
        state <= LOCK0;
        sel   <= SEL_IN0;
        grant <= 2'b01;
      end else if (state == IDLE && win[1]) begin
        state <= LOCK1;
        sel   <= SEL_IN1;
        grant <= 2'b10;
      end else if (rel) begin
        state <= IDLE;
        grant <= 2'b00;
        count <= '0;
        ptr   <= ~sel;
      end else if (acc) begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed and randomized checks of mux2_rr_arbiter against a transaction-level model
module tb_mux2_rr_arbiter;
  localparam int MAXB = 4;
  logic clk, rst_n;
  logic in0_valid, in0_last, in0_ready, in1_valid, in1_last, in1_ready;
  logic [7:0] in0_data, in1_data, out_data;
  logic out_valid, out_last, out_ready, sel;
  logic [1:0] grant;
  int n_chk = 0, n_fail = 0;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .grant(grant)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: owner is -1 when idle, else the index of the requester holding the mux.
  int m_own, m_ptr, m_cnt;
  logic m_ov, m_ol, m_sel;
  logic [7:0] m_od;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= -1; m_ptr <= 0; m_cnt <= 0; m_ov <= 0; m_od <= 0; m_ol <= 0; m_sel <= 0;
    end else if (m_own < 0) begin
      if (in0_valid || in1_valid) begin
        m_own <= (in0_valid && in1_valid) ? m_ptr : (in0_valid ? 0 : 1);
        m_sel <= (in0_valid && in1_valid) ? m_ptr[0] : !in0_valid;
      end
      if (out_ready) m_ov <= 0;
    end else if ((m_own == 1 ? in1_valid : in0_valid) && (!m_ov || out_ready)) begin
      m_ov <= 1;
      m_od <= m_own == 1 ? in1_data : in0_data;
      m_ol <= m_own == 1 ? in1_last : in0_last;
      if ((m_own == 1 ? in1_last : in0_last) || m_cnt + 1 == MAXB) begin
        m_own <= -1; m_cnt <= 0; m_ptr <= 1 - m_own;
      end else m_cnt <= m_cnt + 1;
    end else if (out_ready) m_ov <= 0;
  end

  logic [8:0] q0[$], q1[$], ob[$];
  int oc[$];
  logic [1:0] g_log[$];
  logic s_log[$], r0_log[$], r1_log[$], ov_log[$];
  logic [7:0] od_log[$];

  task automatic drive_idle();
    in0_valid = 0; in0_data = 0; in0_last = 0;
    in1_valid = 0; in1_data = 0; in1_last = 0;
    out_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive_idle();
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Plays the queued packets; in0 is held off for d0 cycles and gapped in [g_s, g_s+g_n),
  // out_ready is low in [lo_s, lo_s+lo_n). Logs per-cycle outputs and consumed beats.
  task automatic run_stream(int cycles, int d0, int lo_s, int lo_n, int g_s, int g_n);
    logic a0, a1;
    g_log.delete(); s_log.delete(); r0_log.delete(); r1_log.delete();
    ov_log.delete(); od_log.delete(); ob.delete(); oc.delete();
    for (int c = 0; c < cycles; c++) begin
      in0_valid = c >= d0 && q0.size() > 0 && !(c >= g_s && c < g_s + g_n);
      in0_data  = q0.size() > 0 ? q0[0][7:0] : 8'h00;
      in0_last  = q0.size() > 0 ? q0[0][8] : 1'b0;
      in1_valid = q1.size() > 0;
      in1_data  = q1.size() > 0 ? q1[0][7:0] : 8'h00;
      in1_last  = q1.size() > 0 ? q1[0][8] : 1'b0;
      out_ready = !(c >= lo_s && c < lo_s + lo_n);
      @(negedge clk);
      g_log.push_back(grant); s_log.push_back(sel);
      r0_log.push_back(in0_ready); r1_log.push_back(in1_ready);
      ov_log.push_back(out_valid); od_log.push_back(out_data);
      a0 = in0_valid && in0_ready;
      a1 = in1_valid && in1_ready;
      if (out_valid && out_ready) begin
        ob.push_back({out_last, out_data});
        oc.push_back(c);
      end
      @(posedge clk);
      #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b exp 00", grant); end
    n_chk++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b exp 0", sel); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    n_chk++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b exp 00", in1_ready, in0_ready); end
    rst_n = 1;
  endtask

  task automatic test_single();
    logic [8:0] ex[$];
    do_reset();
    ex = '{9'h011, 9'h022, 9'h133};
    q0 = ex;
    run_stream(7, 0, 99, 0, 99, 0);
    n_chk++; if (ob.size() != 3) begin n_fail++; $display("FAIL single_count got %0d exp 3", ob.size()); end
    for (int i = 0; i < 3 && i < ob.size(); i++) begin
      n_chk++; if (ob[i] !== ex[i]) begin n_fail++; $display("FAIL single_beat%0d got %h exp %h", i, ob[i], ex[i]); end
    end
    for (int i = 1; i < 3 && i < oc.size(); i++) begin
      n_chk++; if (oc[i] - oc[i-1] != 1) begin n_fail++; $display("FAIL single_gap%0d got %0d exp 1", i, oc[i] - oc[i-1]); end
    end
    n_chk++; if (g_log[0] !== 2'b00 || r0_log[0] !== 1'b0) begin n_fail++; $display("FAIL single_arb_cycle got g=%b r=%b exp g=00 r=0", g_log[0], r0_log[0]); end
    for (int i = 1; i <= 3; i++) begin
      n_chk++; if (g_log[i] !== 2'b01 || s_log[i] !== 1'b0) begin n_fail++; $display("FAIL single_grant%0d got g=%b s=%b exp g=01 s=0", i, g_log[i], s_log[i]); end
    end
    n_chk++; if (g_log[4] !== 2'b00) begin n_fail++; $display("FAIL single_idle got %b exp 00", g_log[4]); end
    q0 = '{9'h1A5};
    q1 = '{9'h1B5};
    run_stream(4, 0, 99, 0, 99, 0);
    n_chk++; if (g_log[1] !== 2'b10 || s_log[1] !== 1'b1) begin n_fail++; $display("FAIL single_ptr got g=%b s=%b exp g=10 s=1", g_log[1], s_log[1]); end
    n_chk++; if (ob.size() < 1 || ob[0] !== 9'h1B5) begin n_fail++; $display("FAIL single_ptr_beat got %h exp 1b5", ob.size() ? ob[0] : 9'h0); end
  endtask

  task automatic test_tie();
    logic [8:0] ex[$];
    do_reset();
    q0 = '{9'h1A0, 9'h1A1};
    q1 = '{9'h1B0, 9'h1B1};
    ex = '{9'h1A0, 9'h1B0, 9'h1A1, 9'h1B1};
    run_stream(12, 0, 99, 0, 99, 0);
    n_chk++; if (ob.size() != 4) begin n_fail++; $display("FAIL tie_count got %0d exp 4", ob.size()); end
    for (int i = 0; i < 4 && i < ob.size(); i++) begin
      n_chk++; if (ob[i] !== ex[i]) begin n_fail++; $display("FAIL tie_beat%0d got %h exp %h", i, ob[i], ex[i]); end
    end
    for (int i = 1; i < oc.size(); i++) begin
      n_chk++; if (oc[i] - oc[i-1] != 2) begin n_fail++; $display("FAIL tie_gap%0d got %0d exp 2", i, oc[i] - oc[i-1]); end
    end
    n_chk++; if (g_log[2] !== 2'b00 || r0_log[2] !== 1'b0 || r1_log[2] !== 1'b0) begin n_fail++; $display("FAIL tie_idle got g=%b r=%b%b exp g=00 r=00", g_log[2], r1_log[2], r0_log[2]); end
  endtask

  task automatic test_max_burst();
    logic [8:0] ex[$];
    do_reset();
    q1 = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015};
    q0 = '{9'h0C0, 9'h1C1};
    ex = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h0C0, 9'h1C1, 9'h014, 9'h015};
    run_stream(16, 1, 99, 0, 99, 0);
    n_chk++; if (ob.size() != 8) begin n_fail++; $display("FAIL burst_count got %0d exp 8", ob.size()); end
    for (int i = 0; i < 8 && i < ob.size(); i++) begin
      n_chk++; if (ob[i] !== ex[i]) begin n_fail++; $display("FAIL burst_beat%0d got %h exp %h", i, ob[i], ex[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] ex[$];
    do_reset();
    ex = '{9'h051, 9'h052, 9'h053, 9'h154};
    q0 = ex;
    run_stream(10, 0, 3, 3, 99, 0);
    for (int c = 3; c < 6; c++) begin
      n_chk++; if (r0_log[c] !== 1'b0 || ov_log[c] !== 1'b1) begin n_fail++; $display("FAIL bp_stall%0d got r=%b v=%b exp r=0 v=1", c, r0_log[c], ov_log[c]); end
      n_chk++; if (od_log[c] !== 8'h52) begin n_fail++; $display("FAIL bp_hold%0d got %h exp 52", c, od_log[c]); end
    end
    n_chk++; if (ob.size() != 4) begin n_fail++; $display("FAIL bp_count got %0d exp 4", ob.size()); end
    for (int i = 0; i < 4 && i < ob.size(); i++) begin
      n_chk++; if (ob[i] !== ex[i]) begin n_fail++; $display("FAIL bp_beat%0d got %h exp %h", i, ob[i], ex[i]); end
    end
  endtask

  task automatic test_owner_gap();
    logic [8:0] ex[$];
    do_reset();
    q0 = '{9'h061, 9'h062, 9'h163};
    q1 = '{9'h171};
    ex = '{9'h061, 9'h062, 9'h163, 9'h171};
    run_stream(10, 0, 99, 0, 2, 2);
    for (int c = 2; c < 4; c++) begin
      n_chk++; if (g_log[c] !== 2'b01 || r1_log[c] !== 1'b0) begin n_fail++; $display("FAIL gap_hold%0d got g=%b r1=%b exp g=01 r1=0", c, g_log[c], r1_log[c]); end
    end
    n_chk++; if (ob.size() != 4) begin n_fail++; $display("FAIL gap_count got %0d exp 4", ob.size()); end
    for (int i = 0; i < 4 && i < ob.size(); i++) begin
      n_chk++; if (ob[i] !== ex[i]) begin n_fail++; $display("FAIL gap_beat%0d got %h exp %h", i, ob[i], ex[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    q1 = '{9'h081, 9'h082, 9'h083, 9'h184};
    run_stream(4, 0, 99, 0, 99, 0);
    n_chk++; if (out_valid !== 1'b1 || grant !== 2'b10) begin n_fail++; $display("FAIL rmid_pre got v=%b g=%b exp v=1 g=10", out_valid, grant); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin n_fail++; $display("FAIL rmid_out got v=%b d=%h l=%b exp 0/00/0", out_valid, out_data, out_last); end
    n_chk++; if (grant !== 2'b00 || sel !== 1'b0) begin n_fail++; $display("FAIL rmid_arb got g=%b s=%b exp 00/0", grant, sel); end
    n_chk++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready got %b%b exp 00", in1_ready, in0_ready); end
    do_reset();
    q0 = '{9'h190};
    q1 = '{9'h191};
    run_stream(6, 0, 99, 0, 99, 0);
    n_chk++; if (g_log[1] !== 2'b01) begin n_fail++; $display("FAIL rmid_tie got %b exp 01", g_log[1]); end
    n_chk++; if (ob.size() < 1 || ob[0] !== 9'h190) begin n_fail++; $display("FAIL rmid_first got %h exp 190", ob.size() ? ob[0] : 9'h0); end
  endtask

  task automatic test_random();
    logic [1:0] eg;
    logic er0, er1;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      in0_valid = $urandom_range(3) != 0;
      in0_data  = 8'($urandom);
      in0_last  = $urandom_range(4) == 0;
      in1_valid = $urandom_range(3) != 0;
      in1_data  = 8'($urandom);
      in1_last  = $urandom_range(4) == 0;
      out_ready = $urandom_range(3) != 0;
      @(negedge clk);
      eg  = m_own == 0 ? 2'b01 : m_own == 1 ? 2'b10 : 2'b00;
      er0 = m_own == 0 && (!m_ov || out_ready);
      er1 = m_own == 1 && (!m_ov || out_ready);
      n_chk++; if (grant !== eg) begin n_fail++; $display("FAIL rnd_grant c=%0d got %b exp %b", c, grant, eg); end
      n_chk++; if (sel !== m_sel) begin n_fail++; $display("FAIL rnd_sel c=%0d got %b exp %b", c, sel, m_sel); end
      n_chk++; if (in0_ready !== er0) begin n_fail++; $display("FAIL rnd_r0 c=%0d got %b exp %b", c, in0_ready, er0); end
      n_chk++; if (in1_ready !== er1) begin n_fail++; $display("FAIL rnd_r1 c=%0d got %b exp %b", c, in1_ready, er1); end
      n_chk++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_ov c=%0d got %b exp %b", c, out_valid, m_ov); end
      n_chk++; if (out_data !== m_od) begin n_fail++; $display("FAIL rnd_od c=%0d got %h exp %h", c, out_data, m_od); end
      n_chk++; if (out_last !== m_ol) begin n_fail++; $display("FAIL rnd_ol c=%0d got %b exp %b", c, out_last, m_ol); end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_single();
    test_tie();
    test_max_burst();
    test_backpressure();
    test_owner_gap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
